// File: rtl/aec_pkg.sv
// Shared types and constants for the ASCII
// arithmetic-expression link.
package aec_pkg;

  localparam logic [7:0] ASC_EQ  = 8'h3D;
  localparam logic [7:0] ASC_LP  = 8'h28;
  localparam logic [7:0] ASC_RP  = 8'h29;
  localparam logic [7:0] ASC_MUL = 8'h2A;
  localparam logic [7:0] ASC_ADD = 8'h2B;
  localparam logic [7:0] ASC_SUB = 8'h2D;

  localparam int RESULT_W = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_EQ,
    S_WAIT,
    S_CAPT,
    S_GAP
  } state_t;

endpackage

// File: rtl/aec_expr_tx_if.sv
// Host and calculator signals of the
// expression transmitter.
interface aec_expr_tx_if;
  import aec_pkg::*;

  logic                wr_en;
  logic [7:0]          wr_char;
  logic                full;
  logic                start;
  logic                busy;
  logic                ready;
  logic [7:0]          ascii_in;
  logic                valid;
  logic [RESULT_W-1:0] result;
  logic                parenthesesLegal;
  logic                done;
  logic [RESULT_W-1:0] res;
  logic                res_legal;
  logic                timeout;

  modport slave (
    input  wr_en, wr_char, start,
    input  valid, result, parenthesesLegal,
    output full, busy, ready, ascii_in,
    output done, res, res_legal, timeout
  );

  modport master (
    output wr_en, wr_char, start,
    output valid, result, parenthesesLegal,
    input  full, busy, ready, ascii_in,
    input  done, res, res_legal, timeout
  );

endinterface

// File: rtl/aec_char_buf.sv
// Append-only character buffer with indexed
// read, fill count and full flag.
module aec_char_buf #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr,
  input  logic [7:0]                 i_data,
  input  logic                       i_clr,
  input  logic [$clog2(DEPTH)-1:0]   i_rd_idx,
  output logic [7:0]                 o_rd_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [7:0]    r_mem [DEPTH];
  logic [CW-1:0] r_cnt;
  logic          w_full;
  logic          w_wr;

  assign w_full = (r_cnt == CW'(DEPTH));
  assign w_wr   = i_wr && !w_full;

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_cnt[IW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (w_wr)
      r_cnt <= r_cnt + CW'(1);
  end

  assign o_rd_data = r_mem[i_rd_idx];
  assign o_count   = r_cnt;
  assign o_full    = w_full;

endmodule

// File: rtl/aec_expr_tx.sv
// Streams a buffered expression plus '=' to the
// calculator and captures its result window.
module aec_expr_tx
  import aec_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 255,
  parameter int GAP     = 2
) (
  input logic            clk,
  input logic            rst,
  aec_expr_tx_if.slave   io_bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam int GW = $clog2(GAP+1);

  state_t              r_state, w_state_nxt;
  logic [IW-1:0]       r_idx, w_idx_nxt;
  logic [TW-1:0]       r_timer, w_timer_nxt;
  logic [GW-1:0]       r_gap, w_gap_nxt;
  logic                r_acc, w_acc_nxt;
  logic [RESULT_W-1:0] r_lat, w_lat_nxt;
  logic                r_done, w_done_nxt;
  logic [RESULT_W-1:0] r_res, w_res_nxt;
  logic                r_res_legal, w_res_legal_nxt;
  logic                r_timeout, w_timeout_nxt;

  logic [7:0]          w_rd_data;
  logic [CW-1:0]       w_cnt;
  logic                w_full;
  logic                w_wr;
  logic                w_wr_ok;
  logic                w_clr;
  logic                w_last;

  assign w_wr    = io_bus.wr_en && (r_state == S_IDLE);
  assign w_wr_ok = w_wr && !w_full;
  assign w_last  = (CW'(r_idx) + CW'(1)) == w_cnt;

  aec_char_buf #(.DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .i_wr      (w_wr),
    .i_data    (io_bus.wr_char),
    .i_clr     (w_clr),
    .i_rd_idx  (r_idx),
    .o_rd_data (w_rd_data),
    .o_count   (w_cnt),
    .o_full    (w_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_timer     <= '0;
      r_gap       <= '0;
      r_acc       <= 1'b0;
      r_lat       <= '0;
      r_done      <= 1'b0;
      r_res       <= '0;
      r_res_legal <= 1'b1;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_timer     <= w_timer_nxt;
      r_gap       <= w_gap_nxt;
      r_acc       <= w_acc_nxt;
      r_lat       <= w_lat_nxt;
      r_done      <= w_done_nxt;
      r_res       <= w_res_nxt;
      r_res_legal <= w_res_legal_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_timer_nxt     = r_timer;
    w_gap_nxt       = r_gap;
    w_acc_nxt       = r_acc;
    w_lat_nxt       = r_lat;
    w_done_nxt      = 1'b0;
    w_res_nxt       = r_res;
    w_res_legal_nxt = r_res_legal;
    w_timeout_nxt   = r_timeout;
    w_clr           = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (io_bus.start) begin
          if ((w_cnt != '0) || w_wr_ok) begin
            w_state_nxt = S_SEND;
            w_idx_nxt   = '0;
          end else begin
            w_done_nxt      = 1'b1;
            w_res_nxt       = '0;
            w_res_legal_nxt = 1'b0;
            w_timeout_nxt   = 1'b0;
          end
        end
      end
      S_SEND: begin
        w_idx_nxt = r_idx + IW'(1);
        if (w_last)
          w_state_nxt = S_EQ;
      end
      S_EQ: begin
        w_state_nxt = S_WAIT;
        w_timer_nxt = '0;
      end
      S_WAIT: begin
        if (io_bus.valid) begin
          w_state_nxt = S_CAPT;
          w_acc_nxt   = io_bus.parenthesesLegal;
          w_lat_nxt   = io_bus.result;
        // done is registered: leave one cycle early
        end else if (r_timer == TW'(TIMEOUT-2)) begin
          w_state_nxt     = S_GAP;
          w_gap_nxt       = '0;
          w_done_nxt      = 1'b1;
          w_res_legal_nxt = 1'b0;
          w_timeout_nxt   = 1'b1;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_CAPT: begin
        if (io_bus.valid) begin
          w_acc_nxt = r_acc & io_bus.parenthesesLegal;
          w_lat_nxt = io_bus.result;
        end else begin
          w_state_nxt     = S_GAP;
          w_gap_nxt       = '0;
          w_done_nxt      = 1'b1;
          w_res_nxt       = r_lat;
          w_res_legal_nxt = r_acc;
          w_timeout_nxt   = 1'b0;
        end
      end
      S_GAP: begin
        if (r_gap == GW'(GAP-1)) begin
          w_state_nxt = S_IDLE;
          w_clr       = 1'b1;
        end else begin
          w_gap_nxt = r_gap + GW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    io_bus.ascii_in = 8'h00;
    if (r_state == S_SEND)
      io_bus.ascii_in = w_rd_data;
    else if (r_state == S_EQ)
      io_bus.ascii_in = ASC_EQ;
  end

  assign io_bus.full      = w_full;
  assign io_bus.busy      = (r_state != S_IDLE);
  assign io_bus.ready     = (r_state == S_SEND) && (r_idx == '0);
  assign io_bus.done      = r_done;
  assign io_bus.res       = r_res;
  assign io_bus.res_legal = r_res_legal;
  assign io_bus.timeout   = r_timeout;

endmodule

// File: tb/tb_aec_expr_tx.sv
// Bench for aec_expr_tx: vector table, random
// transactions and reset/empty-start sequences.
module tb_aec_expr_tx;
  import aec_pkg::*;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 255;
  localparam int GAP     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  aec_expr_tx_if bus();

  aec_expr_tx #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .GAP     (GAP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] wq[$];

  typedef struct packed {
    logic [8*17-1:0] txt;
    int              len;
    int              dly;
    int              vwin;
    logic [6:0]      rval;
    logic [15:0]     legal;
    logic            merge;
    logic [6:0]      eres;
    logic            elegal;
    logic            eto;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, want %0h (t=%0t)",
                 nm, act, exp, $time);
    end
  endtask

  // One full transaction: load wq, start, act as the
  // calculator (valid window of vwin cycles dly cycles
  // after '='), check the stream cycle by cycle.
  task automatic run_txn(input int dly,
                         input int vwin,
                         input logic [6:0] rval,
                         input logic [15:0] lg,
                         input bit merge,
                         input logic [6:0] eres,
                         input logic elegal,
                         input logic eto,
                         input bit chk_res);
    int nw;
    int nsep;
    int n;
    int e;
    int kd;
    logic [7:0] st[$];
    logic [7:0] exp_a;
    nw   = wq.size();
    nsep = merge ? nw - 1 : nw;
    n    = (nw > DEPTH) ? DEPTH : nw;
    for (int i = 0; i < n; i++)
      st.push_back(wq[i]);
    for (int i = 0; i < nsep; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_char = wq[i];
      @(negedge clk);
      chk("full", 32'(bus.full), 32'(i + 1 >= DEPTH));
    end
    bus.wr_en   = merge;
    bus.wr_char = merge ? wq[nw-1] : 8'h00;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    e  = n + 1;
    kd = (vwin > 0) ? e + dly + vwin + 2 : e + TIMEOUT;
    for (int k = 1; k <= kd + 2; k++) begin
      int j;
      if (k <= n)
        exp_a = st[k-1];
      else if (k == n + 1)
        exp_a = ASC_EQ;
      else
        exp_a = 8'h00;
      chk("ascii_in", 32'(bus.ascii_in), 32'(exp_a));
      chk("ready", 32'(bus.ready), 32'(k == 1));
      chk("done", 32'(bus.done), 32'(k == kd));
      chk("busy", 32'(bus.busy), 32'(k <= kd + 1));
      if (k == kd) begin
        if (chk_res)
          chk("res", 32'(bus.res), 32'(eres));
        chk("res_legal", 32'(bus.res_legal), 32'(elegal));
        chk("timeout", 32'(bus.timeout), 32'(eto));
      end
      j = k - (e + 1 + dly);
      bus.valid = (vwin > 0) && (j >= 0) && (j < vwin);
      if (bus.valid) begin
        bus.parenthesesLegal = lg[j];
        bus.result = (j == vwin - 1) ? rval : 7'($urandom);
      end else begin
        bus.parenthesesLegal = 1'($urandom);
        bus.result = 7'($urandom);
      end
      bus.wr_en   = (k >= 2) && (k <= kd + 1);
      bus.wr_char = 8'h58;
      @(negedge clk);
    end
    bus.valid = 1'b0;
    bus.wr_en = 1'b0;
    chk("full_after", 32'(bus.full), 32'(0));
  endtask

  initial begin
    string cs;
    cs = "0123456789+-*()";
    vt[0] = '{txt:"3+4", len:3, dly:2, vwin:1, rval:7,
              legal:16'h1, merge:0, eres:7, elegal:1, eto:0};
    vt[1] = '{txt:"(2+3)*4", len:7, dly:0, vwin:1, rval:20,
              legal:16'h1, merge:0, eres:20, elegal:1, eto:0};
    vt[2] = '{txt:"(2+3", len:4, dly:3, vwin:2, rval:5,
              legal:16'h2, merge:0, eres:5, elegal:0, eto:0};
    vt[3] = '{txt:"1+1", len:3, dly:0, vwin:0, rval:0,
              legal:16'h0, merge:0, eres:0, elegal:0, eto:1};
    vt[4] = '{txt:"11111111111111111", len:17, dly:1, vwin:1,
              rval:16, legal:16'h1, merge:0, eres:16,
              elegal:1, eto:0};
    vt[5] = '{txt:"9-6", len:3, dly:0, vwin:3, rval:3,
              legal:16'h7, merge:1, eres:3, elegal:1, eto:0};
    vt[6] = '{txt:"8", len:1, dly:253, vwin:1, rval:8,
              legal:16'h1, merge:0, eres:8, elegal:1, eto:0};

    bus.wr_en            = 1'b0;
    bus.wr_char          = 8'h00;
    bus.start            = 1'b0;
    bus.valid            = 1'b0;
    bus.result           = '0;
    bus.parenthesesLegal = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_full", 32'(bus.full), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_ready", 32'(bus.ready), 32'(0));
    chk("rst_ascii", 32'(bus.ascii_in), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_res", 32'(bus.res), 32'(0));
    chk("rst_legal", 32'(bus.res_legal), 32'(1));
    chk("rst_timeout", 32'(bus.timeout), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      wq.delete();
      for (int i = 0; i < vt[v].len; i++)
        wq.push_back(vt[v].txt[8*(vt[v].len-1-i) +: 8]);
      run_txn(vt[v].dly, vt[v].vwin, vt[v].rval,
              vt[v].legal, vt[v].merge, vt[v].eres,
              vt[v].elegal, vt[v].eto, !vt[v].eto);
    end

    for (int r = 0; r < 8; r++) begin
      int len;
      int dly;
      int vwin;
      logic [6:0] rval;
      logic [15:0] lg;
      logic acc;
      len  = $urandom_range(1, 16);
      dly  = $urandom_range(0, 30);
      vwin = $urandom_range(0, 4);
      rval = 7'($urandom);
      lg   = 16'($urandom);
      wq.delete();
      for (int i = 0; i < len; i++)
        wq.push_back(cs[$urandom_range(0, 14)]);
      acc = 1'b1;
      for (int j = 0; j < vwin; j++)
        acc = acc & lg[j];
      if (vwin == 0)
        run_txn(dly, 0, rval, lg, 0, rval, 1'b0, 1'b1, 0);
      else
        run_txn(dly, vwin, rval, lg, r[0], rval, acc,
                1'b0, 1);
    end

    for (int i = 0; i < 6; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_char = 8'h31 + 8'(i);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rs_ready1", 32'(bus.ready), 32'(1));
    chk("rs_ascii1", 32'(bus.ascii_in), 32'(8'h31));
    repeat (2) @(negedge clk);
    chk("rs_busy_pre", 32'(bus.busy), 32'(1));
    rst = 1'b1;
    #1;
    chk("rs_ready", 32'(bus.ready), 32'(0));
    chk("rs_ascii", 32'(bus.ascii_in), 32'(0));
    chk("rs_busy", 32'(bus.busy), 32'(0));
    chk("rs_full", 32'(bus.full), 32'(0));
    chk("rs_legal", 32'(bus.res_legal), 32'(1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("empty_done", 32'(bus.done), 32'(1));
    chk("empty_res", 32'(bus.res), 32'(0));
    chk("empty_legal", 32'(bus.res_legal), 32'(0));
    chk("empty_timeout", 32'(bus.timeout), 32'(0));
    chk("empty_busy", 32'(bus.busy), 32'(0));
    chk("empty_ascii", 32'(bus.ascii_in), 32'(0));
    @(negedge clk);
    chk("empty_done_end", 32'(bus.done), 32'(0));
    chk("empty_legal_hold", 32'(bus.res_legal), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
